vcve2_vstore_unit: RTL and testbench
====================================

VCVE2_VSTORE_UNIT -- requirements
Module: vcve2_vstore_unit

Interface
REQ-001 Parameter VLEN, default 128, meaning vector register width in bits (multiple of 32, at least 64).
REQ-002 Derived constant WPR = VLEN/32, meaning 32-bit words per vector register.
REQ-003 clk_i  input  1  clock; the block uses one clock only.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 start_i  input  1  one-cycle pulse that launches a unit-stride vector store (OPCODE_STORE_V).
REQ-006 vs3_i  input  5  first source vector register.
REQ-007 base_addr_i  input  32  memory base address.
REQ-008 vl_i  input  32  element count.
REQ-009 vsew_i  input  3  element width, type vsew_e.
REQ-010 vrf_req_o  output  1  vector register file (VRF) read strobe.
REQ-011 vrf_raddr_o  output  5  VRF register index.
REQ-012 vrf_rword_o  output  $clog2(WPR)  word index within the register.
REQ-013 vrf_rdata_i  input  32  VRF read data, valid exactly 1 cycle after vrf_req_o.
REQ-014 data_req_o, data_gnt_i, data_rvalid_i, data_err_i  1-bit data-bus handshake signals.
REQ-015 data_addr_o  output  32  data-bus address.
REQ-016 data_we_o  output  1  write enable, constant 1.
REQ-017 data_be_o  output  4  byte enables.
REQ-018 data_wdata_o  output  32  write data.
REQ-019 busy_o  output  1  store in progress.
REQ-020 done_o  output  1  one-cycle pulse on successful completion.
REQ-021 err_o  output  1  one-cycle pulse on a rejected or aborted store.

Function
REQ-022 States SHALL be VST_IDLE, VST_READ, VST_CAPT, VST_REQ, VST_WAIT and VST_DONE.
REQ-023 In IDLE with start_i=1, the block SHALL compute nbytes = vl_i << vsew_i and nwords = ceil(nbytes/4), then latch vs3, base address and the word counter (cnt=0).
REQ-024 On start_i, the block SHALL reject the store if vsew_i is not VSEW_8/16/32, if base_addr_i[1:0]!=0, or if vs3_i*WPR + nwords > 32*WPR.
- A rejected store pulses err_o on the next cycle, issues no VRF or bus traffic, and stays in IDLE.
REQ-025 A legal start with vl_i=0 SHALL pulse done_o on the next cycle with no traffic.
REQ-026 Otherwise the block SHALL go IDLE->READ.
REQ-027 READ (one cycle) SHALL assert vrf_req_o with vrf_raddr_o = vs3 + cnt/WPR and vrf_rword_o = cnt%WPR, then go to CAPT.
REQ-028 CAPT SHALL register vrf_rdata_i into the write-data buffer, then go to REQ.
REQ-029 REQ SHALL hold data_req_o=1 with stable addr = base + 4*cnt, wdata and be until data_gnt_i=1, then go to WAIT.
REQ-030 data_be_o SHALL be 4'b1111, except on the last word when nbytes%4 != 0, where it is (1<<(nbytes%4))-1.
REQ-031 WAIT SHALL hold data_req_o=0, with at most one outstanding transaction.
- On data_rvalid_i with data_err_i=0: if cnt=nwords-1, go to DONE; otherwise cnt++ and go to READ.
- On data_rvalid_i with data_err_i=1: pulse err_o, go to IDLE, and issue no further words.
REQ-032 DONE SHALL pulse done_o for one cycle, then go to IDLE.
REQ-033 busy_o SHALL be 1 in every state except IDLE.
REQ-034 start_i SHALL be ignored while busy_o=1.
REQ-035 data_rvalid_i outside WAIT SHALL be ignored.
REQ-036 Arithmetic on nbytes and nwords SHALL be 35-bit (vl_i may overflow 32 bits after the shift); the address SHALL wrap modulo 2^32.
REQ-037 data_gnt_i and data_rvalid_i arriving in the same cycle SHALL both be honoured: grant moves to WAIT, and rvalid is evaluated in the following cycle only if it is still asserted.

Reset
REQ-038 With rst_i=1 at a clock edge, the block SHALL enter IDLE with cnt=0 and all outputs 0, except data_we_o=1.
REQ-039 Reset mid-operation SHALL abandon the store with no done_o or err_o pulse; the bus master tolerates a dropped request.

Structure
REQ-040 Typedef vst_state_t and the VST_* state names SHALL be added to vcve2_pkg; vsew_e SHALL be reused.
REQ-041 Sub-module vcve2_vst_be_gen (nbytes%4 and last flag -> data_be_o) is optional; everything else stays in one module.

Verification
REQ-042 With VLEN=128: vs3=4, base=0x1000, vl=5, SEW8, immediate grants -> VRF reads (4,0) and (4,1); stores to 0x1000 be=1111 and 0x1004 be=0001; done_o pulses once.
REQ-043 vs3=4, vl=6, SEW32 -> VRF reads (4,0..3) then (5,0..1); addresses 0x1000..0x1014 in order, all with be=1111.
REQ-044 base=0x1002 -> err_o pulses 1 cycle after start; vrf_req_o and data_req_o never assert.
REQ-045 vs3=31, vl=5, SEW32 -> err_o, no traffic.
REQ-046 vl=4, SEW16 with data_gnt_i stalled 3 cycles per request -> address and wdata stable while stalled; 2 words stored; done_o pulses.
REQ-047 Two cases:
- Error on the second rvalid of a 4-word store -> err_o, no third request, busy_o=0.
- rst_i asserted in WAIT -> all outputs 0 next cycle, and a new start completes normally.

Source files
------------

// File: rtl/vcve2_pkg.sv
// Shared types for the vcve2 vector store path: element-width encoding and
// store-sequencer state names.
package vcve2_pkg;

    localparam logic [6:0] OPCODE_STORE_V = 7'b0100111;

    typedef enum logic [2:0] {
        VSEW_8  = 3'd0,
        VSEW_16 = 3'd1,
        VSEW_32 = 3'd2,
        VSEW_64 = 3'd3
    } vsew_e;

    typedef enum logic [2:0] {
        VST_IDLE = 3'd0,
        VST_READ = 3'd1,
        VST_CAPT = 3'd2,
        VST_REQ  = 3'd3,
        VST_WAIT = 3'd4,
        VST_DONE = 3'd5
    } vst_state_t;

    // Only 8/16/32-bit elements fit the 32-bit data bus word by word.
    function automatic logic sew_ok(vsew_e s);
        return (s == VSEW_8) || (s == VSEW_16) || (s == VSEW_32);
    endfunction

endpackage

// File: rtl/vcve2_vstore_unit_if.sv
// Command, VRF read port and data-bus signals of the vector store unit.
// master = the store unit, slave = its environment (decoder, VRF, memory).
interface vcve2_vstore_unit_if
    import vcve2_pkg::*;
#(
    parameter int VLEN = 128
) ();
    localparam int WPR = VLEN / 32;
    localparam int RW  = $clog2(WPR);

    logic          start;
    logic [4:0]    vs3;
    logic [31:0]   base_addr;
    logic [31:0]   vl;
    vsew_e         vsew;

    logic          vrf_req;
    logic [4:0]    vrf_raddr;
    logic [RW-1:0] vrf_rword;
    logic [31:0]   vrf_rdata;

    logic          data_req;
    logic          data_gnt;
    logic          data_rvalid;
    logic          data_err;
    logic [31:0]   data_addr;
    logic          data_we;
    logic [3:0]    data_be;
    logic [31:0]   data_wdata;

    logic          busy;
    logic          done;
    logic          err;

    modport master (
        input  start, vs3, base_addr, vl, vsew,
        input  vrf_rdata, data_gnt, data_rvalid, data_err,
        output vrf_req, vrf_raddr, vrf_rword,
        output data_req, data_addr, data_we, data_be, data_wdata,
        output busy, done, err
    );

    modport slave (
        output start, vs3, base_addr, vl, vsew,
        output vrf_rdata, data_gnt, data_rvalid, data_err,
        input  vrf_req, vrf_raddr, vrf_rword,
        input  data_req, data_addr, data_we, data_be, data_wdata,
        input  busy, done, err
    );

endinterface

// File: rtl/vcve2_vstore_unit_be_gen.sv
// Byte-enable generator: full word except a partial last word, where only
// the low (nbytes % 4) bytes are written.
module vcve2_vst_be_gen (
    input  logic [1:0] tail,
    input  logic       last,
    output logic [3:0] be
);

    always_comb begin
        be = 4'b1111;
        if (last) begin
            case (tail)
                2'd1:    be = 4'b0001;
                2'd2:    be = 4'b0011;
                2'd3:    be = 4'b0111;
                default: be = 4'b1111;
            endcase
        end
    end

endmodule

// File: rtl/vcve2_vstore_unit.sv
// Unit-stride vector store sequencer: reads one VRF word at a time and writes
// it to memory with one outstanding bus transaction.
//   state    | meaning
//   VST_IDLE | waiting for start; rejects or finishes trivial stores here
//   VST_READ | VRF read strobe for word cnt
//   VST_CAPT | VRF data arrives, captured into the write buffer
//   VST_REQ  | bus request held until granted
//   VST_WAIT | waiting for the write response
//   VST_DONE | done pulse, back to idle
module vcve2_vstore_unit
    import vcve2_pkg::*;
#(
    parameter int VLEN = 128
) (
    input logic                 clk,
    input logic                 rst,
    vcve2_vstore_unit_if.master bus
);

    localparam int WPR = VLEN / 32;
    localparam int RW  = $clog2(WPR);
    localparam int CW  = $clog2(32 * WPR);
    localparam logic [CW-1:0] WPR_C     = CW'(WPR);
    localparam logic [35:0]   VRF_WORDS = 36'(32 * WPR);

    vst_state_t    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] last_idx;
    logic [1:0]    tail;
    logic [4:0]    vs3_q;
    logic [31:0]   base_q;

    logic          vrf_req_q;
    logic [4:0]    vrf_raddr_q;
    logic [RW-1:0] vrf_rword_q;
    logic          data_req_q;
    logic [31:0]   data_addr_q;
    logic [3:0]    data_be_q;
    logic [31:0]   data_wdata_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    // Start-time sizing; 35 bits because vl << vsew can exceed 32 bits.
    logic [2:0]    sew_c;
    logic [34:0]   nbytes_c;
    logic [34:0]   nwords_c;
    logic [35:0]   span_c;
    logic          legal_c;

    always_comb begin
        sew_c    = bus.vsew;
        nbytes_c = {3'b000, bus.vl} << sew_c;
        nwords_c = (nbytes_c + 35'd3) >> 2;
        span_c   = 36'(bus.vs3) * 36'(WPR) + {1'b0, nwords_c};
        legal_c  = sew_ok(bus.vsew) && (bus.base_addr[1:0] == 2'b00)
                   && (span_c <= VRF_WORDS);
    end

    logic [CW-1:0] cnt_inc;
    logic [3:0]    be_c;

    assign cnt_inc = cnt + CW'(1);

    vcve2_vst_be_gen u_be_gen (
        .tail (tail),
        .last (cnt == last_idx),
        .be   (be_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= VST_IDLE;
            cnt          <= '0;
            last_idx     <= '0;
            tail         <= '0;
            vs3_q        <= '0;
            base_q       <= '0;
            vrf_req_q    <= 1'b0;
            vrf_raddr_q  <= '0;
            vrf_rword_q  <= '0;
            data_req_q   <= 1'b0;
            data_addr_q  <= '0;
            data_be_q    <= '0;
            data_wdata_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                VST_IDLE: begin
                    if (bus.start) begin
                        if (!legal_c) begin
                            err_q <= 1'b1;
                        end else if (nwords_c == 35'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            vs3_q       <= bus.vs3;
                            base_q      <= bus.base_addr;
                            cnt         <= '0;
                            last_idx    <= CW'(nwords_c - 35'd1);
                            tail        <= nbytes_c[1:0];
                            vrf_req_q   <= 1'b1;
                            vrf_raddr_q <= bus.vs3;
                            vrf_rword_q <= '0;
                            busy_q      <= 1'b1;
                            state       <= VST_READ;
                        end
                    end
                end
                VST_READ: begin
                    vrf_req_q <= 1'b0;
                    state     <= VST_CAPT;
                end
                VST_CAPT: begin
                    data_wdata_q <= bus.vrf_rdata;
                    data_addr_q  <= base_q + 32'({cnt, 2'b00});
                    data_be_q    <= be_c;
                    data_req_q   <= 1'b1;
                    state        <= VST_REQ;
                end
                VST_REQ: begin
                    if (bus.data_gnt) begin
                        data_req_q <= 1'b0;
                        state      <= VST_WAIT;
                    end
                end
                VST_WAIT: begin
                    if (bus.data_rvalid) begin
                        if (bus.data_err) begin
                            err_q  <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= VST_IDLE;
                        end else if (cnt == last_idx) begin
                            done_q <= 1'b1;
                            state  <= VST_DONE;
                        end else begin
                            cnt         <= cnt_inc;
                            vrf_req_q   <= 1'b1;
                            vrf_raddr_q <= vs3_q + 5'(cnt_inc / WPR_C);
                            vrf_rword_q <= RW'(cnt_inc % WPR_C);
                            state       <= VST_READ;
                        end
                    end
                end
                VST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= VST_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= VST_IDLE;
                end
            endcase
        end
    end

    assign bus.vrf_req    = vrf_req_q;
    assign bus.vrf_raddr  = vrf_raddr_q;
    assign bus.vrf_rword  = vrf_rword_q;
    assign bus.data_req   = data_req_q;
    assign bus.data_addr  = data_addr_q;
    assign bus.data_we    = 1'b1;
    assign bus.data_be    = data_be_q;
    assign bus.data_wdata = data_wdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_vcve2_vstore_unit.sv
// Scoreboard bench for the vector store unit: stimulus pushes expected VRF
// reads, bus writes and completions; a negedge monitor pops and compares.
module tb_vcve2_vstore_unit;
    import vcve2_pkg::*;

    localparam int VLEN = 128;
    localparam int WPR  = VLEN / 32;
    localparam int RW   = $clog2(WPR);

    logic clk = 1'b0;
    logic rst = 1'b1;

    vcve2_vstore_unit_if #(.VLEN(VLEN)) bus ();

    vcve2_vstore_unit #(.VLEN(VLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    raddr;
        logic [RW-1:0] rword;
    } vrf_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } wr_exp_t;

    vrf_exp_t q_vrf[$];
    wr_exp_t  q_wr[$];
    bit       q_end[$];

    logic [31:0] vrf_mem [32][WPR];

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;
    int hs_count = 0;
    int end_count = 0;
    int end_cycle = 0;

    int cfg_stall    = 0;
    bit cfg_rand_stall = 0;
    int cfg_lat      = 0;
    int cfg_co_pct   = 0;
    bit spurious_en  = 0;
    int err_word     = -1;
    int word_idx     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
    endtask

    always @(posedge clk) cycle++;

    // VRF model and memory-bus responder, driven just after each rising edge.
    initial begin
        bit            rd_pend = 0;
        logic [4:0]    rd_a = '0;
        logic [RW-1:0] rd_w = '0;
        bit            in_req = 0;
        int            stall_left = 0;
        bit            resp_pend = 0;
        int            resp_wait = 0;
        bit            resp_err = 0;
        bus.vrf_rdata   = '0;
        bus.data_gnt    = 1'b0;
        bus.data_rvalid = 1'b0;
        bus.data_err    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_pend) bus.vrf_rdata = vrf_mem[rd_a][rd_w];
            else         bus.vrf_rdata = $urandom;
            rd_pend = 0;
            if (bus.vrf_req) begin
                rd_pend = 1;
                rd_a    = bus.vrf_raddr;
                rd_w    = bus.vrf_rword;
            end
            bus.data_gnt    = 1'b0;
            bus.data_rvalid = 1'b0;
            bus.data_err    = 1'b0;
            if (rst) begin
                in_req    = 0;
                resp_pend = 0;
                rd_pend   = 0;
            end else if (resp_pend) begin
                if (resp_wait == 0) begin
                    bus.data_rvalid = 1'b1;
                    bus.data_err    = resp_err;
                    resp_pend       = 0;
                end else begin
                    resp_wait--;
                end
            end else if (bus.data_req) begin
                if (!in_req) begin
                    in_req     = 1;
                    stall_left = cfg_rand_stall ? int'($urandom_range(0, 3)) : cfg_stall;
                end
                if (stall_left == 0) begin
                    bus.data_gnt = 1'b1;
                    in_req       = 0;
                    resp_err     = (word_idx == err_word);
                    word_idx++;
                    resp_pend    = 1;
                    if (int'($urandom_range(0, 99)) < cfg_co_pct) begin
                        bus.data_rvalid = 1'b1;
                        bus.data_err    = resp_err;
                        resp_wait       = 0;
                    end else begin
                        resp_wait = (cfg_lat < 0) ? int'($urandom_range(0, 3)) : cfg_lat;
                    end
                end else begin
                    stall_left--;
                end
            end else if (spurious_en && $urandom_range(0, 7) == 0) begin
                bus.data_rvalid = 1'b1;
                bus.data_err    = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an output event.
    initial begin
        bit          held = 0;
        logic [31:0] h_addr = '0;
        logic [31:0] h_wdata = '0;
        logic [3:0]  h_be = '0;
        vrf_exp_t    ev;
        wr_exp_t     ew;
        bit          ee;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
            end else begin
                if (bus.vrf_req) begin
                    chk("busy_with_vrf_req", bus.busy, 1);
                    if (q_vrf.size() == 0) chk("vrf_req_unexpected", bus.vrf_req, 0);
                    else begin
                        ev = q_vrf.pop_front();
                        chk("vrf_raddr", bus.vrf_raddr, ev.raddr);
                        chk("vrf_rword", bus.vrf_rword, ev.rword);
                    end
                end
                if (bus.data_req) begin
                    if (held) begin
                        chk("stall_addr_stable", bus.data_addr, h_addr);
                        chk("stall_wdata_stable", bus.data_wdata, h_wdata);
                        chk("stall_be_stable", bus.data_be, h_be);
                    end
                    if (bus.data_gnt) begin
                        held = 0;
                        hs_count++;
                        chk("data_we", bus.data_we, 1);
                        if (q_wr.size() == 0) chk("data_req_unexpected", bus.data_req, 0);
                        else begin
                            ew = q_wr.pop_front();
                            chk("data_addr", bus.data_addr, ew.addr);
                            chk("data_be", bus.data_be, ew.be);
                            chk("data_wdata", bus.data_wdata, ew.wdata);
                        end
                    end else begin
                        held    = 1;
                        h_addr  = bus.data_addr;
                        h_wdata = bus.data_wdata;
                        h_be    = bus.data_be;
                    end
                end else begin
                    held = 0;
                end
                if (bus.done || bus.err) begin
                    end_count++;
                    end_cycle = cycle;
                    if (q_end.size() == 0) chk("end_unexpected", {bus.done, bus.err}, 2'b00);
                    else begin
                        ee = q_end.pop_front();
                        chk("end_kind(done,err)", {bus.done, bus.err}, ee ? 2'b01 : 2'b10);
                    end
                end
                if (bus.err) chk("busy_at_err", bus.busy, 0);
            end
        end
    end

    task automatic flush_queues();
        q_vrf.delete();
        q_wr.delete();
        q_end.delete();
    endtask

    task automatic run_store(input logic [4:0] vs3, input logic [31:0] base,
                             input logic [31:0] vl, input logic [2:0] sew,
                             input int err_w, input bit poke);
        longint esz, nbytes, nwords, tail;
        bit     legal;
        bit     aborted;
        int     ec0, sc;
        vrf_exp_t ev;
        wr_exp_t  ew;
        case (sew)
            3'd0: esz = 1;
            3'd1: esz = 2;
            3'd2: esz = 4;
            default: esz = 0;
        endcase
        nbytes = longint'(vl) * esz;
        nwords = (nbytes + 3) / 4;
        tail   = nbytes % 4;
        legal  = (esz != 0) && (base[1:0] == 2'b00)
                 && (longint'(vs3) * WPR + nwords <= 32 * WPR);
        aborted = 0;
        if (!legal) q_end.push_back(1'b1);
        else if (nwords == 0) q_end.push_back(1'b0);
        else begin
            for (longint i = 0; i < nwords; i++) begin
                ev.raddr = 5'(longint'(vs3) + i / WPR);
                ev.rword = RW'(i % WPR);
                q_vrf.push_back(ev);
                ew.addr  = 32'(longint'(base) + 4 * i);
                ew.be    = (i == nwords - 1 && tail != 0) ? 4'((1 << tail) - 1) : 4'hF;
                ew.wdata = vrf_mem[longint'(vs3) + i / WPR][i % WPR];
                q_wr.push_back(ew);
                if (i == err_w) begin
                    aborted = 1;
                    break;
                end
            end
            q_end.push_back(aborted);
        end
        word_idx = 0;
        err_word = err_w;
        ec0 = end_count;
        @(negedge clk);
        bus.vs3       = vs3;
        bus.base_addr = base;
        bus.vl        = vl;
        bus.vsew      = vsew_e'(sew);
        bus.start     = 1'b1;
        sc = cycle;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.vs3       = 5'($urandom);
        bus.base_addr = $urandom;
        bus.vl        = $urandom;
        if (poke) begin
            repeat (3) @(negedge clk);
            bus.vs3       = 5'd31;
            bus.base_addr = 32'h3;
            bus.vl        = 32'd100;
            bus.vsew      = VSEW_64;
            bus.start     = 1'b1;
            @(negedge clk);
            bus.start     = 1'b0;
        end
        for (int k = 0; k < 3000 && end_count == ec0; k++) @(negedge clk);
        if (end_count == ec0) chk("store_completion_timeout", end_count, ec0 + 1);
        else if (!legal || nwords == 0) chk("immediate_end_latency", end_cycle - sc, 1);
        repeat (3) @(negedge clk);
        chk("vrf_reads_all_seen", q_vrf.size(), 0);
        chk("bus_writes_all_seen", q_wr.size(), 0);
        chk("idle_busy", bus.busy, 0);
        flush_queues();
        err_word = -1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_vrf_req"}, bus.vrf_req, 0);
        chk({tag, "_vrf_raddr"}, bus.vrf_raddr, 0);
        chk({tag, "_vrf_rword"}, bus.vrf_rword, 0);
        chk({tag, "_data_req"}, bus.data_req, 0);
        chk({tag, "_data_addr"}, bus.data_addr, 0);
        chk({tag, "_data_be"}, bus.data_be, 0);
        chk({tag, "_data_wdata"}, bus.data_wdata, 0);
        chk({tag, "_data_we"}, bus.data_we, 1);
    endtask

    initial begin
        int hs0;
        logic [31:0] rvl, rbase;
        logic [2:0]  rsew;
        int          rerr;
        for (int r = 0; r < 32; r++)
            for (int w = 0; w < WPR; w++) vrf_mem[r][w] = $urandom;
        bus.start     = 1'b0;
        bus.vs3       = '0;
        bus.base_addr = '0;
        bus.vl        = '0;
        bus.vsew      = VSEW_8;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;

        run_store(5'd4, 32'h1000, 32'd5, 3'd0, -1, 0);
        run_store(5'd4, 32'h1000, 32'd6, 3'd2, -1, 0);
        run_store(5'd4, 32'h1002, 32'd5, 3'd0, -1, 0);
        run_store(5'd31, 32'h1000, 32'd5, 3'd2, -1, 0);
        run_store(5'd31, 32'h2000, 32'd4, 3'd2, -1, 0);
        run_store(5'd2, 32'h1000, 32'd3, 3'd3, -1, 0);
        run_store(5'd2, 32'h1000, 32'd3, 3'd6, -1, 0);
        run_store(5'd7, 32'h1000, 32'd0, 3'd1, -1, 0);
        run_store(5'd0, 32'h1000, 32'h4000_0001, 3'd2, -1, 0);
        run_store(5'd0, 32'hFFFF_FFF8, 32'd4, 3'd2, -1, 0);
        run_store(5'd9, 32'h300, 32'd7, 3'd1, -1, 0);

        cfg_stall = 3;
        run_store(5'd3, 32'h40, 32'd4, 3'd1, -1, 1);
        cfg_stall = 0;

        cfg_lat = 1;
        run_store(5'd6, 32'h800, 32'd4, 3'd2, 1, 0);
        cfg_co_pct = 100;
        run_store(5'd10, 32'h900, 32'd11, 3'd0, -1, 0);
        cfg_co_pct = 0;

        // Reset while a write response is outstanding.
        cfg_lat = 6;
        for (int i = 0; i < 4; i++) begin
            vrf_exp_t ev;
            wr_exp_t  ew;
            ev.raddr = 5'(2 + i / WPR);
            ev.rword = RW'(i % WPR);
            q_vrf.push_back(ev);
            ew.addr  = 32'h2000 + 32'(4 * i);
            ew.be    = 4'hF;
            ew.wdata = vrf_mem[2 + i / WPR][i % WPR];
            q_wr.push_back(ew);
        end
        word_idx = 0;
        hs0 = hs_count;
        @(negedge clk);
        bus.vs3 = 5'd2; bus.base_addr = 32'h2000; bus.vl = 32'd4; bus.vsew = VSEW_32;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 200 && hs_count == hs0; k++) @(negedge clk);
        chk("grant_before_reset", hs_count, hs0 + 1);
        @(negedge clk);
        chk("busy_in_wait", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_outputs_zero("mid_reset");
        rst = 1'b0;
        flush_queues();
        cfg_lat = 0;
        run_store(5'd2, 32'h2000, 32'd4, 3'd2, -1, 0);

        spurious_en    = 1;
        cfg_rand_stall = 1;
        cfg_lat        = -1;
        cfg_co_pct     = 30;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0:       rvl = 32'd0;
                1:       rvl = $urandom;
                default: rvl = 32'($urandom_range(1, 24));
            endcase
            rbase = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            rsew  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            rerr  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_store(5'($urandom_range(0, 31)), rbase, rvl, rsew, rerr, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
